// File: rtl/perceptron_pkg.sv
// Shared definitions for the N-input perceptron trainer.
//   - FSM state encodings (3-bit constants)
//   - target / decision sign encodings
//   - sat_add: signed add clamped to a given two's-complement width
// The top module's header lists the optional build macro.
package perceptron_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_WAIT   = 3'd1;
  localparam logic [2:0] ST_MAC    = 3'd2;
  localparam logic [2:0] ST_DECIDE = 3'd3;
  localparam logic [2:0] ST_UPDATE = 3'd4;
  localparam logic [2:0] ST_EEND   = 3'd5;
  localparam logic [2:0] ST_DONE   = 3'd6;

  localparam logic [1:0] SIGN_POS  = 2'b01;
  localparam logic [1:0] SIGN_NEG  = 2'b11;
  localparam logic [1:0] SIGN_ZERO = 2'b00;

  // a + d, clamped to [-2^(wb-1), 2^(wb-1)-1]. The sum is formed at 33 bits,
  // so the 32-bit operands themselves cannot overflow.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] d,
                                                 input int wb);
    logic signed [32:0] s, hi, lo;
    s  = {a[31], a} + {d[31], d};
    hi = (33'sd1 <<< (wb - 1)) - 33'sd1;
    lo = -(33'sd1 <<< (wb - 1));
    if (s > hi)      return hi[31:0];
    else if (s < lo) return lo[31:0];
    else             return s[31:0];
  endfunction

endpackage

// File: rtl/perceptron_trainer_n_if.sv
// Training-sample stream: valid/ready handshake carrying one sample.
//   s_valid/s_ready : handshake, transfer when both are high
//   s_x             : N_IN packed signed inputs, x[i] at [i*W +: W]
//   s_t             : target, 01 = +1, 11 = -1
//   s_last          : last sample of the epoch
// master = sample source, slave = trainer.
interface perceptron_trainer_n_if #(
  parameter int N_IN = 2,
  parameter int W    = 14
);
  logic              s_valid;
  logic              s_ready;
  logic [N_IN*W-1:0] s_x;
  logic [1:0]        s_t;
  logic              s_last;

  modport master (output s_valid, s_x, s_t, s_last, input  s_ready);
  modport slave  (input  s_valid, s_x, s_t, s_last, output s_ready);
endinterface

// File: rtl/perceptron_mac.sv
// Sequential multiply/shift/accumulate datapath of the perceptron trainer.
//   init : load acc with the sign-extended bias
//   en   : acc += trunc_AW((x[idx]*w[idx]) >>> FRAC), wrapping
//   idx  : term index, stepped by the controller
//   acc  : AW-bit signed accumulator
module perceptron_mac #(
  parameter int N_IN = 2,
  parameter int W    = 14,
  parameter int FRAC = 8,
  parameter int AW   = 16,
  parameter int IW   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   init,
  input  logic                   en,
  input  logic [IW-1:0]          idx,
  input  logic [N_IN-1:0][W-1:0] x,
  input  logic [N_IN-1:0][W-1:0] w,
  input  logic [W-1:0]           b,
  output logic signed [AW-1:0]   acc
);
  logic signed [2*W-1:0] prod, prod_sh;
  logic signed [AW-1:0]  acc_q, acc_d;

  always_comb begin
    prod    = (2*W)'(signed'(x[idx])) * (2*W)'(signed'(w[idx]));
    prod_sh = prod >>> FRAC;
    acc_d   = acc_q;
    if (init)    acc_d = {{(AW-W){b[W-1]}}, b};
    else if (en) acc_d = acc_q + prod_sh[AW-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) acc_q <= '0;
    else      acc_q <= acc_d;
  end

  assign acc = acc_q;
endmodule

// File: rtl/perceptron_trainer_n.sv
// N-input perceptron trainer. Samples arrive on the stream interface; weights
// and bias are updated in place; training stops after an error-free epoch
// (converged) or after MAX_EPOCHS epochs.
// Ports:
//   clk, rst (async, active low), start (honoured in IDLE/DONE only)
//   s          : sample stream (slave side)
//   epoch_req  : one-cycle pulse asking the source to replay the epoch
//   ready      : training finished; converged valid while ready
//   y_sign     : last decision (01 +1, 11 -1, 00 zero)
//   b, w       : bias and packed weights; epoch_cnt : completed epochs
// Build macro PERCEPTRON_SATURATE_EN: weight/bias updates saturate at W bits
// instead of wrapping. The accumulator wraps in both builds.
module perceptron_trainer_n
  import perceptron_pkg::*;
#(
  parameter  int N_IN        = 2,
  parameter  int W           = 14,
  parameter  int FRAC        = 8,
  parameter  int ALPHA_SHIFT = 0,
  parameter  int THETA       = 0,
  parameter  int MAX_EPOCHS  = 16,
  localparam int EW          = $clog2(MAX_EPOCHS + 1),
  localparam int AW          = W + $clog2(N_IN + 1),
  localparam int IW          = $clog2(N_IN + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  perceptron_trainer_n_if.slave s,
  output logic                 epoch_req,
  output logic                 ready,
  output logic                 converged,
  output logic [1:0]           y_sign,
  output logic [W-1:0]         b,
  output logic [N_IN*W-1:0]    w,
  output logic [EW-1:0]        epoch_cnt
);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_IN - 1);
  localparam logic [IW-1:0] IDX_BIAS = IW'(N_IN);
  localparam logic [EW-1:0] EP_MAX   = EW'(MAX_EPOCHS);
  localparam int            BSTEP    = (1 << FRAC) >>> ALPHA_SHIFT;

  logic [2:0]             state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [N_IN-1:0][W-1:0] x_q, x_d, w_q, w_d;
  logic [W-1:0]           b_q, b_d;
  logic                   tpos_q, tpos_d, last_q, last_d, flag_q, flag_d;
  logic [1:0]             y_q, y_d;
  logic [EW-1:0]          ep_q, ep_d;
  logic                   ready_q, ready_d, conv_q, conv_d, ereq_q, ereq_d;
  logic signed [AW-1:0]   acc;
  logic                   mac_init, mac_en;
  logic signed [31:0]     acc32, xs32, dx;
  logic [1:0]             y_new, t_code;

  // One weight/bias step: wrap or saturate at W bits.
  function automatic logic [W-1:0] upd(input logic [W-1:0] a, input logic signed [31:0] d);
    logic signed [31:0] a32, r;
    a32 = 32'(signed'(a));
`ifdef PERCEPTRON_SATURATE_EN
    r = sat_add(a32, d, W);
`else
    r = a32 + d;
`endif
    return r[W-1:0];
  endfunction

  perceptron_mac #(.N_IN(N_IN), .W(W), .FRAC(FRAC), .AW(AW), .IW(IW)) u_mac (
    .clk  (clk),
    .rst  (rst),
    .init (mac_init),
    .en   (mac_en),
    .idx  (idx_q),
    .x    (x_q),
    .w    (w_q),
    .b    (b_q),
    .acc  (acc)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    x_d      = x_q;
    w_d      = w_q;
    b_d      = b_q;
    tpos_d   = tpos_q;
    last_d   = last_q;
    flag_d   = flag_q;
    y_d      = y_q;
    ep_d     = ep_q;
    ready_d  = ready_q;
    conv_d   = conv_q;
    ereq_d   = 1'b0;
    mac_init = 1'b0;
    mac_en   = 1'b0;

    acc32  = 32'(acc);
    t_code = tpos_q ? SIGN_POS : SIGN_NEG;
    y_new  = (acc32 > THETA)  ? SIGN_POS :
             (acc32 < -THETA) ? SIGN_NEG : SIGN_ZERO;
    xs32   = 32'(signed'(x_q[idx_q])) >>> ALPHA_SHIFT;
    dx     = tpos_q ? xs32 : -xs32;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_d     = '0;
          b_d     = '0;
          ep_d    = '0;
          flag_d  = 1'b1;
          ready_d = 1'b0;
          conv_d  = 1'b0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (s.s_valid) begin
          x_d      = s.s_x;
          tpos_d   = (s.s_t == SIGN_POS);  // any non-01 target counts as -1
          last_d   = s.s_last;
          idx_d    = '0;
          mac_init = 1'b1;
          state_d  = ST_MAC;
        end
      end
      ST_MAC: begin
        mac_en = 1'b1;
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          state_d = ST_DECIDE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DECIDE: begin
        y_d = y_new;
        if (y_new == t_code) begin
          state_d = last_q ? ST_EEND : ST_WAIT;
        end else begin
          flag_d  = 1'b0;
          idx_d   = '0;
          state_d = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        // idx 0..N_IN-1 steps the weights, idx N_IN steps the bias.
        if (idx_q == IDX_BIAS) begin
          b_d     = upd(b_q, tpos_q ? BSTEP : -BSTEP);
          idx_d   = '0;
          state_d = last_q ? ST_EEND : ST_WAIT;
        end else begin
          w_d[idx_q] = upd(w_q[idx_q], dx);
          idx_d      = idx_q + 1'b1;
        end
      end
      ST_EEND: begin
        ep_d = ep_q + 1'b1;
        if (flag_q) begin
          ready_d = 1'b1;
          conv_d  = 1'b1;
          state_d = ST_DONE;
        end else if (ep_d == EP_MAX) begin
          ready_d = 1'b1;
          conv_d  = 1'b0;
          state_d = ST_DONE;
        end else begin
          ereq_d  = 1'b1;
          flag_d  = 1'b1;
          state_d = ST_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      x_q     <= '0;
      w_q     <= '0;
      b_q     <= '0;
      tpos_q  <= 1'b0;
      last_q  <= 1'b0;
      flag_q  <= 1'b0;
      y_q     <= SIGN_ZERO;
      ep_q    <= '0;
      ready_q <= 1'b0;
      conv_q  <= 1'b0;
      ereq_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      w_q     <= w_d;
      b_q     <= b_d;
      tpos_q  <= tpos_d;
      last_q  <= last_d;
      flag_q  <= flag_d;
      y_q     <= y_d;
      ep_q    <= ep_d;
      ready_q <= ready_d;
      conv_q  <= conv_d;
      ereq_q  <= ereq_d;
    end
  end

  assign s.s_ready = (state_q == ST_WAIT);
  assign epoch_req = ereq_q;
  assign ready     = ready_q;
  assign converged = conv_q;
  assign y_sign    = y_q;
  assign b         = b_q;
  assign w         = w_q;
  assign epoch_cnt = ep_q;
endmodule

// File: doc/perceptron_trainer_n.md
Name: perceptron_trainer_n

Overview:
- Parametrised N-input perceptron trainer with a single clock domain.
- Successor to the fixed two-input neuron datapath/controller pair.
- Generalised in input count, weight width and fixed-point format; gains a valid/ready sample stream, epoch limiting and a convergence status.
- Training samples arrive over the stream. Weights and bias are updated in place, and the block reports `ready` once an epoch completes with no updates or the epoch limit is reached.

Parameters:
- `N_IN`, default 2: number of inputs/weights (≥1).
- `W`, default 14: signed width of x, w, b.
- `FRAC`, default 8: fractional bits (Q format).
- `ALPHA_SHIFT`, default 0: learning rate = 2^-ALPHA_SHIFT.
- `THETA`, default 0: decision threshold, in accumulator units (non-negative).
- `MAX_EPOCHS`, default 16: epoch limit (≥1).

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin training; sampled only in IDLE or DONE.
- `s_valid`  in  1  sample valid.
- `s_ready`  out  1  sample accepted when `s_valid && s_ready`.
- `s_x`  in  N_IN*W  inputs, x[i] at bits [i*W +: W], signed.
- `s_t`  in  2  target: 01 = +1, 11 = -1.
- `s_last`  in  1  last sample of epoch.
- `epoch_req`  out  1  one-cycle pulse asking the source to replay the epoch.
- `ready`  out  1  training finished.
- `converged`  out  1  valid while `ready`: 1 = error-free epoch.
- `y_sign`  out  2  last decision: 01 = +1, 11 = -1, 00 = 0.
- `b`  out  W  bias.
- `w`  out  N_IN*W  weights, same packing as `s_x`.
- `epoch_cnt`  out  $clog2(MAX_EPOCHS+1)  completed epochs.

Behaviour:
- Reset (`rst` = 0, asynchronous) clears everything: state IDLE, all outputs 0 (`b`, `w`, `y_sign`, `epoch_cnt`, `ready`, `converged`, `s_ready`, `epoch_req`). Reset mid-operation abandons training immediately.
- FSM states: IDLE, WAIT_S, MAC, DECIDE, UPDATE, EPOCH_END, DONE.
- IDLE/DONE, on `start` = 1:
  - clear `w`, `b`, `epoch_cnt`, the no-change flag, `ready` and `converged`;
  - go to WAIT_S next cycle.
  - `start` is ignored in all other states.
- WAIT_S:
  - `s_ready` = 1 in this state only.
  - On transfer, latch `s_x`, `s_t`, `s_last`; initialise acc = sign-extended b; go to MAC.
  - `s_valid` low holds the state indefinitely.
- MAC: N_IN cycles, one term per cycle, i = 0..N_IN-1.
  - Term: acc += trunc_AW((x[i]*w[i]) >>> FRAC).
  - AW = W + $clog2(N_IN+1).
  - Product is 2W signed; arithmetic shift; wrap-around in acc.
- DECIDE: 1 cycle.
  - y = +1 if acc > THETA; -1 if acc < -THETA; else 0. Register into `y_sign`.
  - If y == t: go to EPOCH_END if `s_last`, else WAIT_S.
  - If y != t: clear the no-change flag; go to UPDATE.
- UPDATE: N_IN+1 cycles.
  - Cycle k < N_IN: w[k] += t*(x[k] >>> ALPHA_SHIFT).
  - Final cycle: b += t*((1<<FRAC) >>> ALPHA_SHIFT).
  - Then go to EPOCH_END if `s_last`, else WAIT_S.
- Per-sample latency (transfer to next `s_ready`): 1 + N_IN + 1 cycles without update; + (N_IN+1) with update.
- EPOCH_END: `epoch_cnt`++, then:
  - flag still set → DONE, `converged` = 1;
  - else if `epoch_cnt` == MAX_EPOCHS → DONE, `converged` = 0;
  - else pulse `epoch_req` for 1 cycle, set the flag, go to WAIT_S.
  - The flag is set at start and at each epoch start.
- DONE: `ready` = 1; weights held until the next `start`.
- A sample whose `s_t` is not 01/11 is treated as -1.

Optional Feature:
- Macro: `PERCEPTRON_SATURATE_EN`.
- Defined: every weight/bias update saturates to [-2^(W-1), 2^(W-1)-1].
- Undefined: two's-complement wrap at W bits.
- The accumulator wraps in both builds.

Decomposition:
- Package `perceptron_pkg`:
  - FSM state enum;
  - target/sign encodings (`SIGN_POS` = 2'b01, `SIGN_NEG` = 2'b11, `SIGN_ZERO` = 2'b00);
  - sat_add function.
- Sub-module `perceptron_mac`: the sequential multiply/shift/accumulate datapath, with the index counter driven by the FSM.

Test Plan:
- Bipolar AND, defaults, x = ±256, samples (1,1,+1), (1,-1,-1), (-1,1,-1), (-1,-1,-1) replayed on each `epoch_req` → `ready` = 1, `converged` = 1, `epoch_cnt` = 2, w = (256,256), b = -256 (14'h3F00), exactly one `epoch_req` pulse.
- Bipolar XOR, MAX_EPOCHS = 4 → `ready` = 1, `converged` = 0, `epoch_cnt` = 4, three `epoch_req` pulses.
- THETA = 32767, two samples x = (8000,0), t = +1 → b = 512 in both builds:
  - with `PERCEPTRON_SATURATE_EN`: w0 = 8191;
  - without: w0 = -384.
- `s_valid` held low for 10 cycles in WAIT_S → `s_ready` stays 1, no state change, no weight change; sample then accepted on the first valid cycle.
- `rst` asserted during UPDATE → all outputs 0 asynchronously (same cycle); FSM in IDLE; `start` after release trains normally.
- `start` pulsed during MAC → ignored; `start` in DONE → weights cleared, `ready` drops the next cycle.
